vedic_seq_mult: RTL and testbench

Iterative unsigned multiplier controller that time-shares a single `vedic2X2` 2×2 core to form a WIDTH×WIDTH product. Operands are split into 2-bit digits. The controller issues one digit pair per cycle to the shared core, shift-accumulates each 4-bit partial product, and returns the 2·WIDTH-bit result over a valid/ready handshake. It sits between an operand producer and a result consumer where area matters more than throughput.

---
 rtl/vedic_seq_mult.sv | 183 ++++++++++++++++++
 tb/tb_vedic_seq_mult.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mult.sv
// vedic_seq_mult: iterative unsigned WIDTH x WIDTH multiplier built around one
// shared vedic2X2 (2-bit x 2-bit) core. One digit pair is multiplied per cycle
// and its 4-bit partial product is shifted into a 2*WIDTH-bit accumulator.
// Optional feature macro: VEDIC_SEQ_ZERO_SKIP_EN. When defined, a zero operand
// bypasses the digit sweep and the zero result appears after one cycle.

// 2x2 unsigned multiplier made from two half adders (Urdhva-Tiryagbhyam form).
module vedic2X2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] pp_o
);
  logic t_lo_cross;
  logic t_hi_cross;
  logic t_hi;
  logic c_mid;

  assign t_lo_cross = a_i[1] & b_i[0];
  assign t_hi_cross = a_i[0] & b_i[1];
  assign t_hi       = a_i[1] & b_i[1];
  assign c_mid      = t_lo_cross & t_hi_cross;

  assign pp_o[0] = a_i[0] & b_i[0];
  assign pp_o[1] = t_lo_cross ^ t_hi_cross;
  assign pp_o[2] = t_hi ^ c_mid;
  assign pp_o[3] = t_hi & c_mid;
endmodule

module vedic_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);
  localparam int D    = WIDTH / 2;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;
  localparam int ND   = 1 << CW;
  localparam int P    = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_r_q;
  logic [WIDTH-1:0] b_r_q;
  logic [P-1:0]     acc_q;
  logic [P-1:0]     acc_d;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    j_q;
  logic             out_valid_q;
  logic [P-1:0]     m_q;

  // Digit views of the captured operands, padded to a power-of-two table so
  // the counter can index it directly; padding entries are never selected.
  logic [1:0] a_dig [ND];
  logic [1:0] b_dig [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_digits
      if (gi < D) begin : g_real
        assign a_dig[gi] = a_r_q[2*gi+1:2*gi];
        assign b_dig[gi] = b_r_q[2*gi+1:2*gi];
      end else begin : g_pad
        assign a_dig[gi] = 2'b00;
        assign b_dig[gi] = 2'b00;
      end
    end
  endgenerate

  logic [1:0]   a_sel;
  logic [1:0]   b_sel;
  logic [3:0]   pp;
  logic [P-1:0] pp_ext;
  logic [P-1:0] pp_shifted;
  logic [CW:0]  ij_sum;
  logic         last_pair;

  assign a_sel = a_dig[i_q];
  assign b_sel = b_dig[j_q];

  vedic2X2 u_core (
    .a_i  (a_sel),
    .b_i  (b_sel),
    .pp_o (pp)
  );

  assign ij_sum    = {1'b0, i_q} + {1'b0, j_q};
  assign pp_ext    = P'(pp);
  assign last_pair = (i_q == LAST) && (j_q == LAST);

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (a == '0) || (b == '0);
`endif

  // Partial product weighted by 4^(i+j) and folded into the running sum.
  always_comb begin
    pp_shifted = '0;
    acc_d      = acc_q;
    pp_shifted = pp_ext << {ij_sum, 1'b0};
    acc_d      = acc_q + pp_shifted;
  end

  // Control FSM with the accumulator, digit counters and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_r_q       <= '0;
      b_r_q       <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      m_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_r_q   <= a;
            b_r_q   <= b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= RUN;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            // Jump straight to the final pair: its product is zero, so one
            // RUN cycle closes the operation with acc still 0.
            if (zero_op) begin
              i_q <= LAST;
              j_q <= LAST;
            end
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_pair) begin
            i_q         <= '0;
            j_q         <= '0;
            m_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + ONE;
          end else begin
            j_q <= j_q + ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign m         = m_q;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Directed and random checks of vedic_seq_mult at WIDTH=8 and WIDTH=4.
module tb_vedic_seq_mult;
  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] m;
  logic        busy;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [7:0]  m4;
  logic        busy4;

  int n_checks;
  int n_errors;

  vedic_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m),
    .busy      (busy)
  );

  vedic_seq_mult #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .m         (m4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Waits for in_ready, presents operands and returns just after the accept edge.
  task automatic start_op(input logic [7:0] ai, input logic [7:0] bi);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ai;
    b = bi;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_mult(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [15:0] exp_m, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    start_op(ai, bi);
    wait_done(lat);
    check_eq({tag, "_m"}, {16'd0, m}, {16'd0, exp_m});
    if (exp_lat > 0) check_eq({tag, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
    check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    $display("op %s: a=%0d b=%0d m=%0d latency=%0d", tag, ai, bi, m, lat);
  endtask

  initial begin
    int lat;
    int zero_lat;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [15:0] rexp;

    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    a4         = '0;
    b4         = '0;
    out_ready4 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_m", {16'd0, m}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    do_mult("13x11", 8'd13, 8'd11, 16'd143, 16);
    do_mult("255x255", 8'd255, 8'd255, 16'hFE01, 16);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    zero_lat = 1;
`else
    zero_lat = 16;
`endif
    do_mult("0x200", 8'd0, 8'd200, 16'd0, zero_lat);
    do_mult("1x1", 8'd1, 8'd1, 16'd1, 16);
    do_mult("128x2", 8'd128, 8'd2, 16'd256, 16);

    // Backpressure, with new operands offered while the multiply runs.
    out_ready = 1'b0;
    start_op(8'd200, 8'd3);
    in_valid = 1'b1;
    a = 8'd77;
    b = 8'd99;
    check_eq("bp_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    in_valid = 1'b0;
    check_eq("bp_lat", lat, 16);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_hold_m", {16'd0, m}, 32'd600);
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    check_eq("bp_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("bp_busy_end", {31'd0, busy}, 32'd0);
    $display("op backpressure: a=200 b=3 m=%0d", m);

    // Reset in the middle of RUN.
    start_op(8'd100, 8'd100);
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_m", {16'd0, m}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_m_after", {16'd0, m}, 32'd0);
    do_mult("2x3", 8'd2, 8'd3, 16'd6, 16);

    // WIDTH=4 instance.
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    a4 = 4'd15;
    b4 = 4'd15;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("w4_lat", lat, 4);
    check_eq("w4_m", {24'd0, m4}, 32'd225);
    $display("op w4: a=15 b=15 m=%0d latency=%0d", m4, lat);
    @(posedge clk); #1;
    check_eq("w4_valid_drop", {31'd0, out_valid4}, 32'd0);

    // Random sweep against the arithmetic reference.
    for (int v = 0; v < 1000; v++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rexp = 16'(ra) * 16'(rb);
      out_ready = 1'b1;
      start_op(ra, rb);
      wait_done(lat);
      check_eq("rand_m", {16'd0, m}, {16'd0, rexp});
      @(posedge clk); #1;
    end
    $display("random sweep: 1000 vectors done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
